pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall controller for the in-order integer pipeline. It tracks the destination of every in-flight instruction between ID and register write-back, up to NUM_STAGES stages deep. Each cycle it drives forwarding-mux selects, load-use/partial-write stalls, bubbles, IF/ID flush and a global freeze for NIC/DMEM wait. It generalises the single-stage RD-compare HDU to N stages, late-result (load/NIC) producers, partial (ppp) writes and a stall counter.

Parameters:
REG_ADDRESS_LENGTH, 5, register address width
NUM_STAGES, 2, tracked post-ID stages (stage 1 = EX/MEM register, stage NUM_STAGES = write-back register); legal range 1..6
SEL_W, $clog2(NUM_STAGES+1), forwarding-select width (derived, not overridden)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_ra, id_rb  in  REG_ADDRESS_LENGTH  source register addresses
id_ra_used, id_rb_used  in  1  source actually read
id_wr_en  in  1  ID instruction writes the register file
id_rd  in  REG_ADDRESS_LENGTH  destination address
id_ppp  in  3  participation field; 3'b000 = full 64-bit write
id_late  in  1  result valid only from stage 2 onward (dmem/NIC load)
br_taken  in  1  branch unit taken signal (ID stage)
mem_wait  in  1  DMEM/NIC not ready; freeze whole pipe
fwd_sel_a, fwd_sel_b  out  SEL_W  0 = register file, k = stage k result
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  zero IF/ID register
idex_bubble  out  1  load NOP into stage 1
hazard_stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock; reset synchronous, active-low.
- Per-stage state: valid, wr_en, rd, full (ppp==000), late. On an advancing edge, entry k moves to k+1 and entry NUM_STAGES retires.
- Stage-1 load: ID fields when id_valid & ~hazard_stall, otherwise a bubble (valid=0).
- Retired entry: committed to the register file on that same edge. ID reads of the register file are asynchronous, so stage NUM_STAGES must still be forwarded.
- Source match: a source counts only when id_valid & *_used. It matches the youngest stage k (lowest index) with valid & wr_en & rd == source. R0 is an ordinary register; there is no zero-register exemption.
- Source resolution:
  - No match: sel=0.
  - Match, full, and not (late & k==1): sel=k.
  - Otherwise the source stalls. A partial write stalls until it retires, including out of stage NUM_STAGES.
- hazard_stall = either source stalls.
- Outputs are combinational from the current state and ID inputs, with zero-cycle decision latency:
  - pc_stall = ifid_stall = hazard_stall | mem_wait
  - idex_bubble = hazard_stall & ~mem_wait
  - ifid_flush = br_taken & ~hazard_stall & ~mem_wait. A branch resolved on stalled operands is ignored and re-evaluated on a later cycle.
- Freeze (mem_wait=1): every stage register holds. The counter does not increment. fwd_sel values are still driven from the held state.
- hazard_stall_cnt: +1 on each edge with hazard_stall & ~mem_wait; saturates at all-ones with no wrap.
- Reset (rst=0 at an edge): all valid bits clear and the counter returns to 0. From then on the outputs are sel=0, all stall/flush/bubble = 0. A reset mid-stall or mid-freeze discards all in-flight tracking.
- Simultaneous events: mem_wait overrides everything. A stall overrides br_taken. Both sources stalling still counts one cycle.

Decomposition:
- Package pipe_ctrl_pkg:
  - ppp encodings (PPP_ALL=3'b000, upper, lower, even, odd)
  - stage-entry struct {valid, wr_en, rd, full, late}
  - SEL_W helper function
- One sub-module, hazard_match: search for one source (inputs: source address, used flag, stage array; outputs: sel, stall). Instantiated twice, for A and B.

Test Plan:
1. NUM_STAGES=2, stage 1 = {wr r3, full, not late}, ID ra=r3 -> fwd_sel_a=1, no stall, counter stays 0.
2. Stage 1 = late load to r5, ID rb=r5 -> cycle 0: pc_stall=1, idex_bubble=1. Next cycle: fwd_sel_b=2, no stall. Counter=1.
3. Stage 1 = r7 ppp=3'b001, ID ra=r7 -> stall for 2 cycles. Then fwd_sel_a=0 once r7 has retired. Counter=2.
4. Stage 1 and stage 2 both write r4 (full), ID ra=rb=r4 -> both sels=1, because the youngest stage wins.
5. Stage 2 = late load to r5, ID ra=r5, mem_wait=1 for 3 cycles -> state held, fwd_sel_a=2, pc_stall=1, idex_bubble=0, counter unchanged.
6. Two cases, then reset:
   - br_taken=1 with no hazard -> ifid_flush=1.
   - br_taken=1 while case-2 stall active -> ifid_flush=0.
   - Assert rst=0 one cycle mid-stall -> all valids cleared, counter=0, sels=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        PPP_ALL   = 3'b000,
        PPP_UPPER = 3'b001,
        PPP_LOWER = 3'b010,
        PPP_EVEN  = 3'b011,
        PPP_ODD   = 3'b100
    } ppp_e;

    // Stage entries carry rd at a fixed maximum width; narrower addresses are zero-extended.
    localparam int RA_W_MAX = 16;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [RA_W_MAX-1:0] rd;
        logic                full;
        logic                late;
    } stage_entry_t;

    function automatic int sel_width(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - resolves one ID source against the in-flight stage entries
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = 2
) (
    input  logic [RA_W_MAX-1:0]            src,
    input  logic                           used,
    input  stage_entry_t [NUM_STAGES-1:0]  stages,
    output logic [SEL_W-1:0]               sel,
    output logic                           stall
);

    logic             hit;
    logic [SEL_W-1:0] hit_pos;
    logic             hit_full;
    logic             hit_late;

    always_comb begin
        hit      = 1'b0;
        hit_pos  = '0;
        hit_full = 1'b0;
        hit_late = 1'b0;
        // Scan oldest to youngest so the youngest matching producer is the one left standing.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stages[k].valid && stages[k].wr_en && (stages[k].rd == src)) begin
                hit      = 1'b1;
                hit_pos  = SEL_W'(k + 1);
                hit_full = stages[k].full;
                hit_late = stages[k].late;
            end
        end

        sel   = '0;
        stall = 1'b0;
        if (used && hit) begin
            if (hit_full && !(hit_late && (hit_pos == SEL_W'(1)))) begin
                sel = hit_pos;
            end else begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - N-stage forwarding, stall, bubble, flush and freeze controller
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int NUM_STAGES         = 2,
    parameter int SEL_W              = sel_width(NUM_STAGES),
    parameter int CNT_W              = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
    input  logic                          id_ra_used,
    input  logic                          id_rb_used,
    input  logic                          id_wr_en,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic [2:0]                    id_ppp,
    input  logic                          id_late,
    input  logic                          br_taken,
    input  logic                          mem_wait,
    output logic [SEL_W-1:0]              fwd_sel_a,
    output logic [SEL_W-1:0]              fwd_sel_b,
    output logic                          pc_stall,
    output logic                          ifid_stall,
    output logic                          ifid_flush,
    output logic                          idex_bubble,
    output logic [CNT_W-1:0]              hazard_stall_cnt
);

    stage_entry_t [NUM_STAGES-1:0] stages;
    stage_entry_t                  id_entry;
    logic [CNT_W-1:0]              cnt;
    logic                          stall_a;
    logic                          stall_b;
    logic                          hazard_stall;

    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.wr_en = id_wr_en;
        id_entry.rd    = RA_W_MAX'(id_rd);
        id_entry.full  = (id_ppp == PPP_ALL);
        id_entry.late  = id_late;
    end

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .SEL_W      (SEL_W)
    ) u_match_a (
        .src    (RA_W_MAX'(id_ra)),
        .used   (id_valid & id_ra_used),
        .stages (stages),
        .sel    (fwd_sel_a),
        .stall  (stall_a)
    );

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .SEL_W      (SEL_W)
    ) u_match_b (
        .src    (RA_W_MAX'(id_rb)),
        .used   (id_valid & id_rb_used),
        .stages (stages),
        .sel    (fwd_sel_b),
        .stall  (stall_b)
    );

    assign hazard_stall     = stall_a | stall_b;
    assign pc_stall         = hazard_stall | mem_wait;
    assign ifid_stall       = hazard_stall | mem_wait;
    assign idex_bubble      = hazard_stall & ~mem_wait;
    // A branch decided on operands that are still stalled is not trusted; it is re-evaluated later.
    assign ifid_flush       = br_taken & ~hazard_stall & ~mem_wait;
    assign hazard_stall_cnt = cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stages <= '0;
            cnt    <= '0;
        end else if (!mem_wait) begin
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                stages[k] <= stages[k-1];
            end
            stages[0] <= (id_valid && !hazard_stall) ? id_entry : '0;
            if (hazard_stall && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int RAW   = 5;
    localparam int NS    = 2;
    localparam int SW    = 2;
    localparam int CW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [RAW-1:0]  id_ra, id_rb, id_rd;
    logic            id_ra_used, id_rb_used, id_wr_en, id_late;
    logic [2:0]      id_ppp;
    logic            br_taken, mem_wait;
    logic [SW-1:0]   fwd_sel_a, fwd_sel_b;
    logic            pc_stall, ifid_stall, ifid_flush, idex_bubble;
    logic [CW-1:0]   hazard_stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDRESS_LENGTH (RAW),
        .NUM_STAGES         (NS),
        .CNT_W              (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_ra            (id_ra),
        .id_rb            (id_rb),
        .id_ra_used       (id_ra_used),
        .id_rb_used       (id_rb_used),
        .id_wr_en         (id_wr_en),
        .id_rd            (id_rd),
        .id_ppp           (id_ppp),
        .id_late          (id_late),
        .br_taken         (br_taken),
        .mem_wait         (mem_wait),
        .fwd_sel_a        (fwd_sel_a),
        .fwd_sel_b        (fwd_sel_b),
        .pc_stall         (pc_stall),
        .ifid_stall       (ifid_stall),
        .ifid_flush       (ifid_flush),
        .idex_bubble      (idex_bubble),
        .hazard_stall_cnt (hazard_stall_cnt)
    );

    typedef struct {
        bit valid;
        bit wr;
        bit full;
        bit late;
        int rd;
    } instr_t;

    typedef struct {
        int      cyc;
        int      sel_a;
        int      sel_b;
        bit      pc;
        bit      ifid;
        bit      flush;
        bit      bubble;
        longint  cnt;
    } exp_t;

    instr_t  in_flight[$];
    exp_t    exp_q[$];
    longint  m_cnt;
    int      cyc;
    int      passed;
    int      total;

    // Youngest in-flight writer of src decides; position in the queue is the stage number minus one.
    task automatic resolve(input int src, input bit used, output int sel, output bit stall);
        sel   = 0;
        stall = 0;
        if (!used) return;
        for (int k = 0; k < in_flight.size(); k++) begin
            if (in_flight[k].valid && in_flight[k].wr && in_flight[k].rd == src) begin
                if (in_flight[k].full && !(in_flight[k].late && k == 0)) sel = k + 1;
                else stall = 1;
                return;
            end
        end
    endtask

    task automatic clear_model();
        in_flight.delete();
        for (int k = 0; k < NS; k++) in_flight.push_back('{0, 0, 0, 0, 0});
        m_cnt = 0;
    endtask

    task automatic step(input bit v, input int ra, input bit rau, input int rb, input bit rbu,
                        input bit wr, input int rd, input int ppp, input bit late,
                        input bit br, input bit mw, input bit rstn);
        exp_t   e;
        int     sa, sb;
        bit     ta, tb;
        bit     hs;
        instr_t ni;
        @(posedge clk);
        #1;
        id_valid = v; id_ra = RAW'(ra); id_ra_used = rau; id_rb = RAW'(rb); id_rb_used = rbu;
        id_wr_en = wr; id_rd = RAW'(rd); id_ppp = 3'(ppp); id_late = late;
        br_taken = br; mem_wait = mw; rst = rstn;

        resolve(ra, v && rau, sa, ta);
        resolve(rb, v && rbu, sb, tb);
        hs       = ta || tb;
        e.cyc    = cyc;
        e.sel_a  = sa;
        e.sel_b  = sb;
        e.pc     = hs || mw;
        e.ifid   = hs || mw;
        e.bubble = hs && !mw;
        e.flush  = br && !hs && !mw;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
        cyc++;

        if (!rstn) begin
            clear_model();
        end else if (!mw) begin
            ni = (v && !hs) ? '{1, wr, (ppp == 0), late, rd} : '{0, 0, 0, 0, 0};
            in_flight.push_front(ni);
            void'(in_flight.pop_back());
            if (hs && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
    endtask

    task automatic idle(input bit mw = 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mw, 1);
    endtask

    task automatic check(input string name, input longint got, input longint want, input int c);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, got, want);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("fwd_sel_a", fwd_sel_a, e.sel_a, e.cyc);
            check("fwd_sel_b", fwd_sel_b, e.sel_b, e.cyc);
            check("stall_bubble_flush",
                  {pc_stall, ifid_stall, idex_bubble, ifid_flush},
                  {e.pc, e.ifid, e.bubble, e.flush}, e.cyc);
            check("hazard_stall_cnt", hazard_stall_cnt, e.cnt, e.cyc);
        end
    end

    initial begin
        passed = 0; total = 0; cyc = 0;
        rst = 0; id_valid = 0; id_ra = 0; id_rb = 0; id_ra_used = 0; id_rb_used = 0;
        id_wr_en = 0; id_rd = 0; id_ppp = 0; id_late = 0; br_taken = 0; mem_wait = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst = 1;

        // Reset state
        idle();
        // 1: full producer in stage 1 forwards from stage 1
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1);
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(); idle();
        // 2: late load in stage 1 stalls once, then forwards from stage 2
        step(1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 1);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        idle(); idle();
        // 3: partial write stalls until retired
        step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 1);
        repeat (3) step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(); idle();
        // 4: youngest of two writers wins
        step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1);
        step(1, 4, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1);
        idle(); idle();
        // 5: freeze with late load held in stage 2
        step(1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 1);
        idle();
        repeat (3) step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(); idle();
        // 6: branch without hazard, branch under stall, reset mid-stall
        step(1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 1);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 1);
        step(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 6, 1, 6, 1, 0, 0, 0, 0, 1, 0, 1);

        // Random traffic over a small register window to provoke frequent hazards
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 4) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 99) != 0);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
